// File: rtl/mem_fill_arbiter.sv
// Main-memory port arbiter: write-through stores and 8-word I/D block fills.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate I/D when both misses contend.
module mem_fill_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_miss,
  input  logic [15:0]                    i_addr,
  input  logic                           d_miss,
  input  logic [15:0]                    d_addr,
  input  logic                           d_wr_req,
  input  logic [15:0]                    d_wr_data,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [15:0]                    mem_addr,
  output logic [15:0]                    mem_wdata,
  input  logic [15:0]                    mem_rdata,
  input  logic                           mem_rvalid,
  output logic [15:0]                    fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           i_fill_we,
  output logic                           d_fill_we,
  output logic                           i_fill_done,
  output logic                           d_fill_done,
  output logic                           d_wr_done,
  output logic                           busy
);

  localparam int WW = $clog2(BLOCK_WORDS);
  localparam logic [15:0] BMASK = ~16'(2 * BLOCK_WORDS - 1);
  localparam logic [WW-1:0] LAST = WW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

  state_t        state;
  logic          own_i;
  logic [15:0]   base;
  logic [WW:0]   iss_cnt;
  logic [WW-1:0] rcv_cnt;
  logic          gnt_i;
  logic          gnt_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_i;

  // contention goes to the side the previous fill did not serve
  assign gnt_d = d_miss && (!i_miss || last_i);
  assign gnt_i = i_miss && (!d_miss || !last_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_i <= 1'b0;
    end else if (state == IDLE && !d_wr_req && (gnt_i || gnt_d)) begin
      last_i <= gnt_i;
    end
  end
`else
  assign gnt_d = d_miss;
  assign gnt_i = i_miss && !d_miss;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      own_i   <= 1'b0;
      base    <= '0;
      iss_cnt <= '0;
      rcv_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          iss_cnt <= '0;
          rcv_cnt <= '0;
          if (d_wr_req) begin
            state <= WRITE;
          end else if (gnt_d || gnt_i) begin
            state <= FILL;
            own_i <= gnt_i;
            base  <= (gnt_i ? i_addr : d_addr) & BMASK;
          end
        end
        WRITE: state <= IDLE;
        FILL: begin
          if (!iss_cnt[WW]) iss_cnt <= iss_cnt + 1'b1;
          if (mem_rvalid) begin
            rcv_cnt <= rcv_cnt + 1'b1;
            if (rcv_cnt == LAST) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_done   = 1'b0;
    unique case (state)
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wr_data;
        d_wr_done = 1'b1;
      end
      FILL: begin
        mem_en    = !iss_cnt[WW];
        mem_addr  = base + 16'({iss_cnt[WW-1:0], 1'b0});
        fill_word = rcv_cnt;
        i_fill_we = mem_rvalid && own_i;
        d_fill_we = mem_rvalid && !own_i;
      end
      DONE: begin
        i_fill_done = own_i;
        d_fill_done = !own_i;
      end
      default: ;
    endcase
  end

  assign fill_data = mem_rdata;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench for mem_fill_arbiter with a fixed-latency memory model.
// Honors MEM_ARB_ROUND_ROBIN_EN when predicting grant order.
module tb_mem_fill_arbiter;

  localparam int L = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  k;
    logic [15:0] a;
    logic [15:0] d;
    logic [2:0]  w;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_addr, d_addr, d_wr_data;
  logic        mem_en, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done;
  logic        d_wr_done, busy;

  int   cyc = 0;
  int   vectors = 0;
  int   mis = 0;
  int   c0;
  ev_t  qm[$];
  ev_t  qf[$];
  ev_t  qd[$];

  mem_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_addr(d_addr),
    .d_wr_req(d_wr_req), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_done(d_wr_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // fixed-latency pipelined memory; read data is address ^ 16'h5A5A
  logic [L-1:0] pv = '0;
  logic [15:0]  pa [L];
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], mem_en && !mem_wr};
    pa[0] <= mem_addr;
    for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
  end
  assign mem_rvalid = pv[L-1];
  assign mem_rdata  = pv[L-1] ? (pa[L-1] ^ 16'h5A5A) : 16'h0;

  function automatic ev_t mk(input int c, input logic [1:0] k,
                             input logic [15:0] a, input logic [15:0] d,
                             input logic [2:0] w);
    ev_t e;
    e.cyc = c;
    e.k   = k;
    e.a   = a;
    e.d   = d;
    e.w   = w;
    return e;
  endfunction

  function automatic string chn(input int ch);
    return ch == 0 ? "mem" : (ch == 1 ? "fill" : "done");
  endfunction

  task automatic check_ev(input int ch, input ev_t got);
    ev_t exp;
    bit  have = 0;
    case (ch)
      0: if (qm.size() > 0) begin exp = qm.pop_front(); have = 1; end
      1: if (qf.size() > 0) begin exp = qf.pop_front(); have = 1; end
      default: if (qd.size() > 0) begin exp = qd.pop_front(); have = 1; end
    endcase
    vectors++;
    if (!have) begin
      mis++;
      $display("FAIL %s unexpected: got c=%0d k=%0d a=%h d=%h w=%0d, required none",
               chn(ch), got.cyc, got.k, got.a, got.d, got.w);
    end else if (got !== exp) begin
      mis++;
      $display("FAIL %s: got c=%0d k=%0d a=%h d=%h w=%0d, required c=%0d k=%0d a=%h d=%h w=%0d",
               chn(ch), got.cyc, got.k, got.a, got.d, got.w,
               exp.cyc, exp.k, exp.a, exp.d, exp.w);
    end
  endtask

  always @(negedge clk) begin
    if (mem_en)
      check_ev(0, mk(cyc, {mem_wr, d_wr_done}, mem_addr,
                     mem_wr ? mem_wdata : 16'h0, 3'd0));
    if (i_fill_we || d_fill_we)
      check_ev(1, mk(cyc, {d_fill_we, i_fill_we}, 16'h0, fill_data, fill_word));
    if (i_fill_done || d_fill_done || (d_wr_done && !mem_en))
      check_ev(2, mk(cyc, {d_fill_done, i_fill_done}, 16'h0, 16'h0, 3'd0));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      mis++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  // c1 = first issue cycle; nrx = words expected back before any abort
  task automatic push_fill(input int c1, input bit is_i,
                           input logic [15:0] addr, input int nrx);
    logic [15:0] b;
    logic [15:0] wa;
    b = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      wa = b + 16'(2 * k);
      qm.push_back(mk(c1 + k, 2'd0, wa, 16'h0, 3'd0));
    end
    for (int k = 0; k < nrx; k++) begin
      wa = b + 16'(2 * k);
      qf.push_back(mk(c1 + L + k, is_i ? 2'd1 : 2'd2, 16'h0,
                      wa ^ 16'h5A5A, 3'(k)));
    end
    if (nrx == 8)
      qd.push_back(mk(c1 + L + 8, is_i ? 2'd1 : 2'd2, 16'h0, 16'h0, 3'd0));
  endtask

  task automatic wait_for(input int which);
    bit seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      tick();
      case (which)
        0: seen = i_fill_done;
        1: seen = d_fill_done;
        default: seen = d_wr_done;
      endcase
    end
    vectors++;
    if (!seen) begin
      mis++;
      $display("FAIL wait%0d: got no pulse in 60 cycles, required pulse", which);
    end
  endtask

  task automatic drain(input int ch);
    ev_t e;
    int  n;
    n = ch == 0 ? qm.size() : (ch == 1 ? qf.size() : qd.size());
    for (int i = 0; i < n; i++) begin
      case (ch)
        0: e = qm.pop_front();
        1: e = qf.pop_front();
        default: e = qd.pop_front();
      endcase
      vectors++;
      mis++;
      $display("FAIL %s missing: got nothing, required c=%0d k=%0d a=%h d=%h w=%0d",
               chn(ch), e.cyc, e.k, e.a, e.d, e.w);
    end
  endtask

  initial begin
    rst       = 1'b0;
    i_miss    = 1'b0;
    d_miss    = 1'b0;
    d_wr_req  = 1'b0;
    i_addr    = '0;
    d_addr    = '0;
    d_wr_data = '0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_fill_we", {i_fill_we, d_fill_we}, 0);
    chk("rst_done", {i_fill_done, d_fill_done, d_wr_done}, 0);
    chk("rst_fill_word", fill_word, 0);
    rst = 1'b1;
    tick();

    // I fill of a mid-block address
    c0 = cyc;
    i_miss = 1'b1;
    i_addr = 16'h0126;
    push_fill(c0 + 1, 1'b1, 16'h0126, 8);
    tick();
    chk("t1_busy", busy, 1);
    wait_for(0);
    tick();
    i_miss = 1'b0;

    // both misses together: D first, I granted in D's trailing IDLE
    tick();
    c0 = cyc;
    d_miss = 1'b1;
    i_miss = 1'b1;
    d_addr = 16'h2008;
    i_addr = 16'h3010;
    push_fill(c0 + 1, 1'b0, 16'h2008, 8);
    push_fill(c0 + 15, 1'b1, 16'h3010, 8);
    wait_for(1);
    tick();
    d_miss = 1'b0;
    wait_for(0);
    tick();
    i_miss = 1'b0;

    // single store
    tick();
    c0 = cyc;
    d_wr_req  = 1'b1;
    d_addr    = 16'h4002;
    d_wr_data = 16'hBEEF;
    qm.push_back(mk(c0 + 1, 2'd3, 16'h4002, 16'hBEEF, 3'd0));
    wait_for(2);
    tick();
    d_wr_req = 1'b0;
    chk("t3_busy_c2", busy, 0);

    // store raised mid I fill waits for the fill to finish
    tick();
    c0 = cyc;
    i_miss = 1'b1;
    i_addr = 16'h0500;
    push_fill(c0 + 1, 1'b1, 16'h0500, 8);
    repeat (3) tick();
    d_wr_req  = 1'b1;
    d_addr    = 16'h4100;
    d_wr_data = 16'h1234;
    qm.push_back(mk(c0 + 15, 2'd3, 16'h4100, 16'h1234, 3'd0));
    tick();
    chk("t4_busy", busy, 1);
    wait_for(0);
    tick();
    i_miss = 1'b0;
    wait_for(2);
    tick();
    d_wr_req = 1'b0;

    // D fill, then both misses pending
    tick();
    c0 = cyc;
    d_miss = 1'b1;
    d_addr = 16'h6000;
    push_fill(c0 + 1, 1'b0, 16'h6000, 8);
    wait_for(1);
    tick();
    d_miss = 1'b0;
    tick();
    c0 = cyc;
    d_miss = 1'b1;
    i_miss = 1'b1;
    d_addr = 16'h6100;
    i_addr = 16'h7000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_fill(c0 + 1, 1'b1, 16'h7000, 8);
    push_fill(c0 + 15, 1'b0, 16'h6100, 8);
    wait_for(0);
    tick();
    i_miss = 1'b0;
    wait_for(1);
    tick();
    d_miss = 1'b0;
`else
    push_fill(c0 + 1, 1'b0, 16'h6100, 8);
    push_fill(c0 + 15, 1'b1, 16'h7000, 8);
    wait_for(1);
    tick();
    d_miss = 1'b0;
    wait_for(0);
    tick();
    i_miss = 1'b0;
`endif

    // reset while the receive counter sits at 3
    tick();
    c0 = cyc;
    i_miss = 1'b1;
    i_addr = 16'h0800;
    push_fill(c0 + 1, 1'b1, 16'h0800, 4);
    repeat (8) tick();
    rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_mem_en", mem_en, 0);
    chk("t6_rvalid_late", mem_rvalid, 1);
    chk("t6_fill_we", {i_fill_we, d_fill_we}, 0);
    i_miss = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("t6_busy_after", busy, 0);

    // top-of-memory block after the abort
    c0 = cyc;
    d_miss = 1'b1;
    d_addr = 16'hFFFE;
    push_fill(c0 + 1, 1'b0, 16'hFFFE, 8);
    wait_for(1);
    tick();
    d_miss = 1'b0;

    repeat (5) tick();
    drain(0);
    drain(1);
    drain(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, mis);
    $finish;
  end

endmodule

// File: doc/mem_fill_arbiter.md
# mem_fill_arbiter

Single-port main-memory controller for the pipelined 16-bit CPU. It arbitrates between instruction-cache misses, data-cache misses and data-side write-through stores. It sequences 8-word block fills from the pipelined memory and steers the returned words into the requesting cache. The pipeline registers (IF/ID … MEM/WB) hold while the matching miss is pending; this block owns the memory port during that time.

## Interface
- BLOCK_WORDS, 8, words per cache block (power of 2; word index width = log2(BLOCK_WORDS))
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_miss  in  1  I-cache miss; held high until i_fill_done
- i_addr  in  16  I-side byte address of miss
- d_miss  in  1  D-cache read miss; held high until d_fill_done
- d_addr  in  16  D-side byte address (miss or store)
- d_wr_req  in  1  D-side store request; held high until d_wr_done
- d_wr_data  in  16  store data
- mem_en  out  1  memory request valid this cycle
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_rvalid  in  1  mem_rdata valid; returns in issue order, fixed latency
- fill_data  out  16  word to write into cache (= mem_rdata)
- fill_word  out  3  word index within block
- i_fill_we  out  1  I-cache array write enable
- d_fill_we  out  1  D-cache array write enable
- i_fill_done  out  1  one-cycle pulse: I block complete
- d_fill_done  out  1  one-cycle pulse: D block complete
- d_wr_done  out  1  one-cycle pulse: store accepted
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WRITE, FILL, DONE.
- IDLE grant priority: d_wr_req > d_miss > i_miss.
- On grant, latch owner (I/D) and base = addr & 16'hFFF0 (block aligned, 2 bytes per word).
- WRITE (1 cycle): mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wr_data, d_wr_done=1. Next state is IDLE.
- FILL:
  - Issue counter 0..7. While counter < 8: mem_en=1, mem_wr=0, mem_addr=base+2*counter, counter increments. No mem_en after 8 issues.
  - Receive counter 0..7 advances on each mem_rvalid.
  - fill_word = receive counter; fill_data = mem_rdata; owner's fill_we = mem_rvalid.
  - mem_rvalid with receive counter == 7 → DONE.
- DONE (1 cycle): owner's *_fill_done=1. Next state is IDLE. Requests are ignored in DONE.
- Requests that arrive while busy wait; no preemption.
- mem_rvalid outside FILL is ignored (no fill_we).
- Outputs are combinational from state/counters; all are 0 in IDLE except busy=0 and fill_data=mem_rdata.
- Reset (any state, including mid-fill): state=IDLE, counters=0, owner=D, RR pointer=D; all control outputs are 0.

## Timing
- Grant edge is the first rising edge with a request in IDLE. The first issue is in the following cycle (cycle 1).
- Memory latency L: data for an issue in cycle k returns in cycle k+L.
- Fill sequence: issues in cycles 1–8; fill_we in cycles 1+L … 8+L; DONE in 9+L; IDLE in 10+L. A back-to-back grant is possible at edge 10+L.
- Store: request in IDLE at cycle 0; WRITE/d_wr_done in cycle 1; IDLE in cycle 2.
- The requester must deassert its miss/req in the cycle after its done pulse.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: when d_miss and i_miss are both pending in IDLE with no d_wr_req, grant goes to the side not served by the last fill. The pointer updates at each fill grant and resets to D. d_wr_req keeps absolute priority.
- Undefined: fixed priority d_wr_req > d_miss > i_miss; no pointer register.

## Test plan
- i_miss, i_addr=16'h0126, L=4 → mem_addr 0x0120..0x012E in cycles 1–8; i_fill_we cycles 5–12 with fill_word 0..7; i_fill_done cycle 13; d_fill_we never set.
- d_miss and i_miss raised together (macro off) → D block filled first; I fill grant at D's IDLE cycle; I fill completes 14 cycles after D fill_done.
- d_wr_req, d_addr=16'h4002, d_wr_data=16'hBEEF → cycle 1: mem_en=1, mem_wr=1, addr 0x4002, wdata 0xBEEF, d_wr_done=1; busy=0 in cycle 2.
- d_wr_req raised during an I fill → waits; WRITE occurs in the cycle after IDLE resumes; the fill is unaffected.
- MEM_ARB_ROUND_ROBIN_EN: D fill, then both misses pending → I is granted; with the macro off, D is granted.
- rst low during FILL at receive counter 3 → busy=0 and no mem_en immediately; late mem_rvalid pulses after release produce no fill_we.
